// File: rtl/matrix_op_executor.sv
// Matrix operation executor: transpose, add, scalar multiply and matrix multiply
// over a synchronous-read matrix store, one result element written per pass.
module matrix_op_executor #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int RES_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_calc,
    input  logic [3:0]        op_type,
    input  logic [DIM_W-1:0]  a_rows,
    input  logic [DIM_W-1:0]  a_cols,
    input  logic [DIM_W-1:0]  b_rows,
    input  logic [DIM_W-1:0]  b_cols,
    input  logic [DATA_W-1:0] scalar,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [DIM_W-1:0]  a_rd_row,
    output logic [DIM_W-1:0]  a_rd_col,
    output logic [DIM_W-1:0]  b_rd_row,
    output logic [DIM_W-1:0]  b_rd_col,
    input  logic [DATA_W-1:0] a_rd_data,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              wr_en,
    output logic [DIM_W-1:0]  wr_row,
    output logic [DIM_W-1:0]  wr_col,
    output logic [RES_W-1:0]  wr_data,
    output logic [DIM_W-1:0]  res_rows,
    output logic [DIM_W-1:0]  res_cols,
    output logic              busy,
    output logic              calc_done,
    output logic              error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam logic [2:0] S_HOLD  = 3'd7;

    localparam logic [3:0] OP_TR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SC  = 4'b0100;
    localparam logic [3:0] OP_MM  = 4'b1000;

    localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

    logic [2:0]              state;
    logic                    start_q;
    logic [DIM_W-1:0]        i, j, k;
    logic signed [RES_W-1:0] acc;

    logic is_tr, is_add, is_sc, is_mm;
    logic start_pe;
    logic check_err;
    logic [DIM_W-1:0] nxt_rows, nxt_cols;
    logic [DIM_W-1:0] last_k;

    assign is_tr    = (op_type == OP_TR);
    assign is_add   = (op_type == OP_ADD);
    assign is_sc    = (op_type == OP_SC);
    assign is_mm    = (op_type == OP_MM);
    assign start_pe = start_calc & ~start_q;
    assign last_k   = a_cols - 1'b1;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= MAX_D);
    endfunction

    always_comb begin
        check_err = 1'b1;
        nxt_rows  = '0;
        nxt_cols  = '0;
        if (is_tr) begin
            check_err = !(dim_ok(a_rows) && dim_ok(a_cols));
            nxt_rows  = a_cols;
            nxt_cols  = a_rows;
        end else if (is_add) begin
            check_err = !(dim_ok(a_rows) && dim_ok(a_cols)) ||
                        (a_rows != b_rows) || (a_cols != b_cols);
            nxt_rows  = a_rows;
            nxt_cols  = a_cols;
        end else if (is_sc) begin
            check_err = !(dim_ok(a_rows) && dim_ok(a_cols));
            nxt_rows  = a_rows;
            nxt_cols  = a_cols;
        end else if (is_mm) begin
            check_err = !(dim_ok(a_rows) && dim_ok(a_cols) &&
                          dim_ok(b_rows) && dim_ok(b_cols)) ||
                        (a_cols != b_rows);
            nxt_rows  = a_rows;
            nxt_cols  = b_cols;
        end
    end

    // Operands and products sign-extended to the accumulator width
    logic signed [2*DATA_W-1:0] prod_ab, prod_as;
    logic signed [RES_W-1:0]    a_ext, b_ext, ab_ext, as_ext;

    assign prod_ab = $signed(a_rd_data) * $signed(b_rd_data);
    assign prod_as = $signed(a_rd_data) * $signed(scalar);
    assign a_ext   = {{(RES_W-DATA_W){a_rd_data[DATA_W-1]}}, a_rd_data};
    assign b_ext   = {{(RES_W-DATA_W){b_rd_data[DATA_W-1]}}, b_rd_data};
    assign ab_ext  = {{(RES_W-2*DATA_W){prod_ab[2*DATA_W-1]}}, prod_ab};
    assign as_ext  = {{(RES_W-2*DATA_W){prod_as[2*DATA_W-1]}}, prod_as};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            res_rows <= '0;
            res_cols <= '0;
        end else begin
            start_q <= start_calc;
            case (state)
                S_IDLE:  if (start_pe) state <= S_CHECK;
                S_CHECK: begin
                    res_rows <= nxt_rows;
                    res_cols <= nxt_cols;
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                    acc <= '0;
                    if (!start_calc)    state <= S_IDLE;
                    else if (check_err) state <= S_ERR;
                    else                state <= S_READ;
                end
                S_READ:  state <= start_calc ? S_ACC : S_IDLE;
                S_ACC: begin
                    if (!start_calc) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_tr)       acc <= a_ext;
                        else if (is_add) acc <= a_ext + b_ext;
                        else if (is_sc)  acc <= as_ext;
                        else if (is_mm)  acc <= acc + ab_ext;
                        if (is_mm && (k != last_k)) begin
                            k     <= k + 1'b1;
                            state <= S_READ;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (!start_calc) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= '0;
                        k   <= '0;
                        if (j == res_cols - 1'b1) begin
                            j <= '0;
                            if (i == res_rows - 1'b1) begin
                                state <= S_DONE;
                            end else begin
                                i     <= i + 1'b1;
                                state <= S_READ;
                            end
                        end else begin
                            j     <= j + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_DONE:  state <= S_HOLD;
                S_ERR:   state <= S_HOLD;
                S_HOLD:  if (!start_calc) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and addresses decode from state so an asynchronous reset clears them at once
    assign busy      = (state != S_IDLE) && (state != S_HOLD);
    assign calc_done = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign a_rd_en   = (state == S_READ);
    assign b_rd_en   = (state == S_READ) && (is_add || is_mm);
    assign a_rd_row  = a_rd_en ? (is_tr ? j : i) : '0;
    assign a_rd_col  = a_rd_en ? (is_tr ? i : (is_mm ? k : j)) : '0;
    assign b_rd_row  = b_rd_en ? (is_mm ? k : i) : '0;
    assign b_rd_col  = b_rd_en ? j : '0;
    assign wr_en     = (state == S_WRITE);
    assign wr_row    = wr_en ? i : '0;
    assign wr_col    = wr_en ? j : '0;
    assign wr_data   = wr_en ? acc : '0;

endmodule
